// File: rtl/mig_pkg.sv
// Shared constants and types for the programmable MIG truth-table generator.
package mig_pkg;
  localparam int N_IN_DEF    = 7;
  localparam int N_NODES_DEF = 6;
  localparam int SEL_W       = $clog2(1 + N_IN_DEF + N_NODES_DEF);

  // Fanin selector space: const0, then primary inputs, then node outputs.
  localparam int SEL_CONST0 = 0;
  localparam int SEL_X_BASE = 1;
  localparam int SEL_W_BASE = SEL_X_BASE + N_IN_DEF;

  typedef struct packed {
    logic             inv;
    logic [SEL_W-1:0] sel;
  } fanin_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mig_comb_eval.sv
// Combinational MIG evaluation: registered config + one input vector -> f.
module mig_comb_eval
  import mig_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_NODES = N_NODES_DEF,
  parameter int SEL_W   = $clog2(1 + N_IN + N_NODES)
) (
  input  logic [N_NODES-1:0][3*(SEL_W+1)-1:0] node_cfg,
  input  logic [SEL_W:0]                      out_cfg,
  input  logic [N_IN-1:0]                     x,
  output logic                                f
);
  localparam int FW = SEL_W + 1;
  localparam int VW = 2**SEL_W;

  // Value space indexed directly by selector; nodes fill in as they are
  // evaluated, which is safe because a node only ever looks at lower nodes.
  logic [VW-1:0] v;
  logic [2:0]    a;

  always_comb begin
    v = '0;
    a = '0;
    v[SEL_X_BASE +: N_IN] = x;
    for (int j = 0; j < N_NODES; j++) begin
      for (int k = 0; k < 3; k++)
        a[k] = v[node_cfg[j][k*FW +: SEL_W]] ^ node_cfg[j][k*FW + SEL_W];
      v[SEL_X_BASE + N_IN + j] = (a[0] & a[1]) | (a[0] & a[2]) | (a[1] & a[2]);
    end
    f = v[out_cfg[SEL_W-1:0]] ^ out_cfg[SEL_W];
  end
endmodule

// File: rtl/mig_truth_table_gen.sv
// Runtime-programmable MIG evaluator with full truth-table sweep and single-vector query.
module mig_truth_table_gen
  import mig_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_NODES = N_NODES_DEF,
  parameter int SEL_W   = $clog2(1 + N_IN + N_NODES),
  parameter int TT_W    = 2**N_IN
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [$clog2(N_NODES+1)-1:0]   cfg_addr,
  input  logic [3*(SEL_W+1)-1:0]         cfg_data,
  output logic                           cfg_err,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [TT_W-1:0]                tt,
  input  logic                           q_valid,
  input  logic [N_IN-1:0]                q_x,
  output logic                           q_ready,
  output logic                           q_out_vld,
  output logic                           q_out
);
  localparam int FW = SEL_W + 1;
  localparam int AW = $clog2(N_NODES + 1);
  localparam int CW = N_IN + 1;

  state_t                         state;
  logic [N_NODES-1:0][3*FW-1:0]   node_cfg;
  logic [FW-1:0]                  out_cfg;
  logic [CW-1:0]                  m;
  logic                           f_sweep, f_query;
  logic                           wr_legal, wr_ok, wr_bad, start_acc, q_acc;

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign q_ready   = !busy && !start;
  assign start_acc = start && !busy;
  assign q_acc     = q_valid && q_ready;

  // Node j may only see x inputs and w[k<j]; the output may see any w.
  always_comb begin
    wr_legal = 1'b1;
    if (cfg_addr > AW'(N_NODES))
      wr_legal = 1'b0;
    else if (cfg_addr == AW'(N_NODES))
      wr_legal = (cfg_data[SEL_W-1:0] <= SEL_W'(N_IN + N_NODES));
    else
      for (int k = 0; k < 3; k++)
        if (int'(cfg_data[k*FW +: SEL_W]) > N_IN + int'(cfg_addr))
          wr_legal = 1'b0;
  end

  assign wr_ok  = cfg_we && !busy && wr_legal;
  assign wr_bad = cfg_we && !wr_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      node_cfg  <= '0;
      out_cfg   <= '0;
      m         <= '0;
      tt        <= '0;
      cfg_err   <= 1'b0;
      q_out_vld <= 1'b0;
      q_out     <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (cfg_addr == AW'(N_NODES)) out_cfg <= cfg_data[FW-1:0];
        else                          node_cfg[cfg_addr] <= cfg_data;
      end
      // A dropped write in the same cycle as a start still reports.
      cfg_err   <= (cfg_err && !start_acc) || wr_bad;
      q_out_vld <= q_acc;
      if (q_acc) q_out <= f_query;
      case (state)
        ST_RUN: begin
          tt[m[N_IN-1:0]] <= f_sweep;
          m               <= m + 1'b1;
          if (m == CW'(TT_W - 1)) state <= ST_DONE;
        end
        default: begin
          if (start) begin
            state <= ST_RUN;
            m     <= '0;
            tt    <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  mig_comb_eval #(.N_IN(N_IN), .N_NODES(N_NODES), .SEL_W(SEL_W)) u_sweep (
    .node_cfg (node_cfg),
    .out_cfg  (out_cfg),
    .x        (m[N_IN-1:0]),
    .f        (f_sweep)
  );

  mig_comb_eval #(.N_IN(N_IN), .N_NODES(N_NODES), .SEL_W(SEL_W)) u_query (
    .node_cfg (node_cfg),
    .out_cfg  (out_cfg),
    .x        (q_x),
    .f        (f_query)
  );
endmodule

// File: tb/tb_mig_truth_table_gen.sv
// Randomised + directed bench for mig_truth_table_gen against a behavioural MIG model.
module tb_mig_truth_table_gen;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_addr = '0;
  logic [14:0]  cfg_data = '0;
  logic         start = 1'b0;
  logic         q_valid = 1'b0;
  logic [6:0]   q_x = '0;
  logic         cfg_err, busy, done, q_ready, q_out_vld, q_out;
  logic [127:0] tt;

  int vecs = 0;
  int errs = 0;

  mig_truth_table_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .start(start), .busy(busy), .done(done), .tt(tt),
    .q_valid(q_valid), .q_x(q_x), .q_ready(q_ready), .q_out_vld(q_out_vld), .q_out(q_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         nsel[6][3];
  bit         ninv[6][3];
  int         osel;
  bit         oinv;
  bit         m_err;
  int         e = -1;      // cycles since accepted start (1..128 running, 129 done)
  bit [127:0] ftab;
  bit         m_qv, m_q;

  function automatic bit pick(input bit [6:0] x, input bit [5:0] w, input int s);
    if (s == 0) return 1'b0;
    if (s <= 7) return x[s-1];
    return w[s-8];
  endfunction

  function automatic bit eval(input bit [6:0] x);
    bit [5:0] w = '0;
    int cnt;
    for (int j = 0; j < 6; j++) begin
      cnt = 0;
      for (int k = 0; k < 3; k++) cnt += int'(pick(x, w, nsel[j][k]) ^ ninv[j][k]);
      w[j] = (cnt >= 2);
    end
    return pick(x, w, osel) ^ oinv;
  endfunction

  function automatic bit [127:0] full_table();
    bit [127:0] t;
    for (int i = 0; i < 128; i++) t[i] = eval(7'(i));
    return t;
  endfunction

  function automatic bit legal(input int a, input bit [14:0] d);
    if (a > 6) return 1'b0;
    if (a == 6) return int'(d[3:0]) <= 13;
    for (int k = 0; k < 3; k++) if (int'(d[k*5 +: 4]) > 7 + a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit [127:0] lowmask(input int n);
    if (n >= 128) return '1;
    return (128'd1 << n) - 128'd1;
  endfunction

  always @(posedge clk) begin
    bit bsy;
    bsy = (e >= 1 && e <= 128);
    if (!rst_n) begin
      for (int j = 0; j < 6; j++) for (int k = 0; k < 3; k++) begin nsel[j][k] = 0; ninv[j][k] = 0; end
      osel = 0; oinv = 0; m_err = 0; e = -1; m_qv = 0; m_q = 0;
    end else begin
      m_qv = q_valid && !start && !bsy;
      if (m_qv) m_q = eval(q_x);
      if (start && !bsy) m_err = 0;
      if (cfg_we) begin
        if (bsy || !legal(int'(cfg_addr), cfg_data)) m_err = 1;
        else if (cfg_addr == 3'd6) begin osel = int'(cfg_data[3:0]); oinv = cfg_data[4]; end
        else for (int k = 0; k < 3; k++) begin
          nsel[cfg_addr][k] = int'(cfg_data[k*5 +: 4]);
          ninv[cfg_addr][k] = cfg_data[k*5 + 4];
        end
      end
      if (start && !bsy) begin ftab = full_table(); e = 1; end
      else if (e >= 1 && e < 200) e++;
    end
  end

  always @(negedge clk) begin
    bit bsy;
    int n;
    bsy = (e >= 1 && e <= 128);
    n = (e < 1) ? 0 : ((e - 1 > 128) ? 128 : e - 1);
    chk("busy", 128'(busy), 128'(bsy));
    chk("done", 128'(done), 128'(e == 129));
    chk("q_ready", 128'(q_ready), 128'(!bsy && !start));
    chk("cfg_err", 128'(cfg_err), 128'(m_err));
    chk("q_out_vld", 128'(q_out_vld), 128'(m_qv));
    if (m_qv) chk("q_out", 128'(q_out), 128'(m_q));
    chk("tt", tt, ftab & lowmask(n));
  end

  // ---------------- directed helpers ----------------
  task automatic wr(input logic [2:0] a, input logic [14:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic sweep(output int n);
    start = 1'b1;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start = 1'b0;
      if (done) break;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 300 && !done) begin @(posedge clk); #1; n++; end
    chk("done_seen", 128'(done), 128'd1);
  endtask

  task automatic query(input logic [6:0] x, input logic exp);
    q_valid = 1'b1; q_x = x;
    @(posedge clk); #1;
    q_valid = 1'b0;
    chk("dq_vld", 128'(q_out_vld), 128'd1);
    chk("dq_out", 128'(q_out), 128'(exp));
  endtask

  initial begin
    int n;
    bit seen;
    logic [14:0] d;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    sweep(n);
    chk("lat_reset", 128'(n), 128'd129);
    chk("tt_zero", tt, 128'd0);

    wr(3'd0, {5'd3, 5'd2, 5'd1});
    wr(3'd6, 15'd8);
    sweep(n);
    chk("lat_maj", 128'(n), 128'd129);
    chk("tt_maj", tt, {16{8'hE8}});

    wr(3'd6, 15'h18);
    sweep(n);
    chk("tt_maj_inv", tt, {16{8'h17}});

    wr(3'd6, 15'd8);
    query(7'b0000011, 1'b1);
    query(7'b0000100, 1'b0);

    start = 1'b1; q_valid = 1'b1; q_x = 7'b0000111;
    #1 chk("q_ready_start", 128'(q_ready), 128'd0);
    @(posedge clk); #1;
    start = 1'b0; q_valid = 1'b0;
    chk("q_blocked", 128'(q_out_vld), 128'd0);
    wait_done();

    wr(3'd0, {5'd3, 5'd2, 5'd9});
    chk("err_illegal", 128'(cfg_err), 128'd1);
    sweep(n);
    chk("err_cleared", 128'(cfg_err), 128'd0);
    chk("tt_unchanged", tt, {16{8'hE8}});

    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk); #1;
    wr(3'd0, {5'd1, 5'd1, 5'd1});
    chk("err_busy", 128'(cfg_err), 128'd1);
    wait_done();
    chk("tt_busy_drop", tt, {16{8'hE8}});

    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (49) @(posedge clk); #1;
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_tt", tt, 128'd0);
    seen = 1'b0;
    repeat (200) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    chk("rst_no_done", 128'(seen), 128'd0);

    wr(3'd6, 15'h10);
    sweep(n);
    chk("tt_ones", tt, {128{1'b1}});

    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      cfg_we  = ($urandom_range(0, 3) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      d = '0;
      for (int k = 0; k < 3; k++) begin
        d[k*5 +: 4] = ($urandom_range(0, 3) != 0)
                      ? 4'($urandom_range(0, 7 + ((cfg_addr > 3'd6) ? 6 : int'(cfg_addr))))
                      : 4'($urandom_range(0, 15));
        d[k*5 + 4]  = 1'($urandom_range(0, 1));
      end
      cfg_data = d;
      start    = ($urandom_range(0, 39) == 0);
      q_valid  = 1'($urandom_range(0, 1));
      q_x      = 7'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; cfg_we = 1'b0; start = 1'b0; q_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
